// File: rtl/rs_parity_encoder.sv
// Systematic RS(K+4,K) encoder over GF(256)/0x11D, 1-cycle latency; data passes through, 4 parity follow.
// Registered output stage stalls everything while out_valid && !out_ready; RS_PARITY_INVERT_EN inverts parity.
module rs_parity_encoder #(
    parameter int K = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_parity,
    output logic       out_last
);

    typedef enum logic {
        ST_DATA,
        ST_PARITY
    } state_t;

    localparam logic [7:0] K_LAST   = 8'(K - 1);
    localparam logic [7:0] PAR_LAST = 8'd3;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] r0_q, r1_q, r2_q, r3_q;
    logic [7:0] r0_d, r1_d, r2_d, r3_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_parity_q, out_parity_d;
    logic       out_last_q, out_last_d;
    logic       out_free;
    logic [7:0] fb;
    logic [7:0] parity_sym;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // Constant-coefficient callers let synthesis fold this into a small XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == ST_DATA) && out_free;

`ifdef RS_PARITY_INVERT_EN
    assign parity_sym = ~r3_q;
`else
    assign parity_sym = r3_q;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        r0_d         = r0_q;
        r1_d         = r1_q;
        r2_d         = r2_q;
        r3_d         = r3_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_parity_d = out_parity_q;
        out_last_d   = out_last_q;
        fb           = in_data ^ r3_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            ST_DATA: begin
                if (in_valid && in_ready) begin
                    r3_d         = r2_q ^ gf_mul(fb, 8'h0F);
                    r2_d         = r1_q ^ gf_mul(fb, 8'h36);
                    r1_d         = r0_q ^ gf_mul(fb, 8'h78);
                    r0_d         = gf_mul(fb, 8'h40);
                    out_data_d   = in_data;
                    out_valid_d  = 1'b1;
                    out_parity_d = 1'b0;
                    out_last_d   = 1'b0;
                    if (count_q == K_LAST) begin
                        count_d = 8'd0;
                        state_d = ST_PARITY;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (out_free) begin
                    out_data_d   = parity_sym;
                    r3_d         = r2_q;
                    r2_d         = r1_q;
                    r1_d         = r0_q;
                    r0_d         = 8'h00;
                    out_valid_d  = 1'b1;
                    out_parity_d = 1'b1;
                    out_last_d   = 1'b0;
                    // Shifting out four symbols leaves the LFSR clear for the next frame.
                    if (count_q == PAR_LAST) begin
                        out_last_d = 1'b1;
                        count_d    = 8'd0;
                        state_d    = ST_DATA;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_DATA;
            count_q      <= 8'd0;
            r0_q         <= 8'h00;
            r1_q         <= 8'h00;
            r2_q         <= 8'h00;
            r3_q         <= 8'h00;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            r0_q         <= r0_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            r3_q         <= r3_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_parity = out_parity_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_rs_parity_encoder.sv
// Bench for rs_parity_encoder: long-division RS model + scoreboard, stalls, mid-frame reset, K=1 instance.
module tb_rs_parity_encoder;

    localparam int K = 24;
`ifdef RS_PARITY_INVERT_EN
    localparam logic [7:0] PMASK = 8'hFF;
`else
    localparam logic [7:0] PMASK = 8'h00;
`endif
    localparam logic [7:0] GEN [5] = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    localparam logic [7:0] K1_D [5] = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    localparam logic       K1_P [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic       K1_L [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    typedef logic [7:0] sym_q_t[$];
    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_parity;
    logic       out_last;

    logic [7:0] in1_data;
    logic       in1_valid;
    logic       in1_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready = 1'b1;
    logic       out1_parity;
    logic       out1_last;

    int tests = 0;
    int fails = 0;
    int ready_pct = 100;
    bit full_rate = 1'b0;
    int cyc = 0;
    int start_cyc = 0;
    exp_t exp_q[$];
    logic [7:0] obs[$];

    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_parity;
    logic       prev_last;

    always #5 clk = ~clk;

    rs_parity_encoder #(.K(K)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_parity(out_parity), .out_last(out_last)
    );

    rs_parity_encoder #(.K(1)) dut_k1 (
        .clk(clk), .rst(rst),
        .in_data(in1_data), .in_valid(in1_valid), .in_ready(in1_ready),
        .out_data(out1_data), .out_valid(out1_valid), .out_ready(out1_ready),
        .out_parity(out1_parity), .out_last(out1_last)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Polynomial multiply then reduce by x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 32'h100) != 0) x = x ^ 32'h11D;
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] gpow(input int n);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < n; i++) p = gmul(p, 8'h02);
        return p;
    endfunction

    // Codeword = message followed by the remainder of m(x)*x^4 divided by g(x).
    function automatic sym_q_t encode(input sym_q_t msg);
        sym_q_t w;
        logic [7:0] c;
        w = msg;
        for (int j = 0; j < 4; j++) w.push_back(8'h00);
        for (int i = 0; i < msg.size(); i++) begin
            c = w[i];
            for (int j = 1; j < 5; j++) w[i + j] = w[i + j] ^ gmul(c, GEN[j]);
        end
        for (int i = 0; i < msg.size(); i++) w[i] = msg[i];
        return w;
    endfunction

    task automatic push_codeword(input sym_q_t cw);
        exp_t e;
        int k;
        k = cw.size() - 4;
        for (int i = 0; i < cw.size(); i++) begin
            e.p = (i >= k);
            e.d = e.p ? (cw[i] ^ PMASK) : cw[i];
            e.l = (i == k + 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_literal(input sym_q_t msg, input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input logic [7:0] p3);
        sym_q_t cw;
        cw = msg;
        cw.push_back(p0);
        cw.push_back(p1);
        cw.push_back(p2);
        cw.push_back(p3);
        push_codeword(cw);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_frame(input sym_q_t msg, input int gap_pct);
        int n;
        bit done;
        for (int i = 0; i < msg.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            n = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                done = in_valid && in_ready;
                @(posedge clk);
                #1;
                n++;
                if (!done && n > 1000) begin
                    check_int("in_accept_timeout", n, 0);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int("drain_remaining", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic sym_q_t rand_frame();
        sym_q_t m;
        for (int i = 0; i < K; i++) m.push_back(8'($urandom_range(255)));
        return m;
    endfunction

    always begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(99) < ready_pct);
    end

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] s;
        logic [7:0] x;
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
            obs.delete();
        end else begin
            if (prev_stall) begin
                check1("stall_valid", out_valid, 1'b1);
                check8("stall_data", out_data, prev_data);
                check1("stall_parity", out_parity, prev_parity);
                check1("stall_last", out_last, prev_last);
            end
            if (out_valid && out_parity && !out_last) check1("in_ready_in_parity", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_int("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check8("out_data", out_data, e.d);
                    check1("out_parity", out_parity, e.p);
                    check1("out_last", out_last, e.l);
                end
                if (obs.size() == 0) start_cyc = cyc;
                obs.push_back(out_parity ? (out_data ^ PMASK) : out_data);
                if (out_last) begin
                    for (int r = 0; r < 4; r++) begin
                        x = gpow(r);
                        s = 8'h00;
                        foreach (obs[i]) s = gmul(s, x) ^ obs[i];
                        check8("codeword_root", s, 8'h00);
                    end
                    if (full_rate) check_int("codeword_cycles", cyc - start_cyc, K + 3);
                    obs.delete();
                end
            end
            prev_stall  = out_valid && !out_ready;
            prev_data   = out_data;
            prev_parity = out_parity;
            prev_last   = out_last;
        end
    end

    initial begin
        sym_q_t zeros;
        sym_q_t one;
        sym_q_t msg;
        sym_q_t part;
        sym_q_t cw;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        in1_valid = 1'b0;
        in1_data = 8'h00;
        for (int i = 0; i < K; i++) zeros.push_back(8'h00);
        for (int i = 0; i < K - 1; i++) one.push_back(8'h00);
        one.push_back(8'h01);

        repeat (3) @(posedge clk);
        #1;
        check1("reset_out_valid", out_valid, 1'b0);
        check8("reset_out_data", out_data, 8'h00);
        check1("reset_out_parity", out_parity, 1'b0);
        check1("reset_out_last", out_last, 1'b0);
        check1("reset_k1_out_valid", out1_valid, 1'b0);
        rst = 1'b0;

        // Pin the reference model to hand-derived values.
        check8("model_gmul", gmul(8'h80, 8'h02), 8'h1D);
        cw = encode(zeros);
        for (int j = 0; j < 4; j++) check8("model_zero_parity", cw[K + j], 8'h00);
        cw = encode(one);
        check8("model_one_p0", cw[K], 8'h0F);
        check8("model_one_p1", cw[K + 1], 8'h36);
        check8("model_one_p2", cw[K + 2], 8'h78);
        check8("model_one_p3", cw[K + 3], 8'h40);

        @(posedge clk);
        #1;
        full_rate = 1'b1;
        ready_pct = 100;
        push_literal(zeros, 8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(zeros, 0);
        push_literal(one, 8'h0F, 8'h36, 8'h78, 8'h40);
        send_frame(one, 0);
        drain();

        for (int f = 0; f < 1000; f++) begin
            msg = rand_frame();
            push_codeword(encode(msg));
            send_frame(msg, 0);
        end
        drain();

        full_rate = 1'b0;
        ready_pct = 60;
        for (int f = 0; f < 150; f++) begin
            msg = rand_frame();
            push_codeword(encode(msg));
            send_frame(msg, 25);
        end
        drain();
        ready_pct = 100;
        @(posedge clk);
        #1;

        // Abort a frame after 10 symbols, then a clean frame must encode without residue.
        msg = rand_frame();
        push_codeword(encode(msg));
        part = msg[0:9];
        send_frame(part, 0);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check1("midreset_out_valid", out_valid, 1'b0);
        check8("midreset_out_data", out_data, 8'h00);
        check1("midreset_out_parity", out_parity, 1'b0);
        check1("midreset_out_last", out_last, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        full_rate = 1'b1;
        push_literal(one, 8'h0F, 8'h36, 8'h78, 8'h40);
        send_frame(one, 0);
        drain();

        in1_valid = 1'b1;
        in1_data  = 8'h01;
        @(negedge clk);
        check1("k1_in_ready", in1_ready, 1'b1);
        @(posedge clk);
        #1;
        in1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("k1_out_valid", out1_valid, 1'b1);
            check8("k1_out_data", out1_data, K1_P[i] ? (K1_D[i] ^ PMASK) : K1_D[i]);
            check1("k1_out_parity", out1_parity, K1_P[i]);
            check1("k1_out_last", out1_last, K1_L[i]);
        end
        @(negedge clk);
        check1("k1_idle_after", out1_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs_parity_encoder.md
Name: rs_parity_encoder

Overview:
- Streaming systematic Reed-Solomon encoder over GF(256), field polynomial 0x11D, primitive element alpha = 0x02.
- Produces 4 parity symbols per frame of K data symbols; this is the transmit-side counterpart of the CD decoder datapath.
- Data symbols pass through unchanged, then the 4 parity symbols follow, highest-degree first.
- Generator polynomial g(x) = (x+1)(x+a)(x+a^2)(x+a^3) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.

Parameters:
K  24  data symbols per frame; legal range 1..251. Codeword length is K+4.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_data  input  8  data symbol
in_valid  input  1  in_data is valid
in_ready  output  1  encoder accepts in_data this cycle
out_data  output  8  codeword symbol (data or parity)
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data this cycle
out_parity  output  1  current out_data is a parity symbol
out_last  output  1  current out_data is the last symbol of the codeword

Behaviour:
- Interface: one clock `clk`; asynchronous active-high reset `rst`.
- Reset (asynchronous, immediate):
  - LFSR r0..r3 = 0; symbol counter = 0; state = DATA.
  - out_valid = 0, out_data = 0x00, out_parity = 0, out_last = 0.
- out_free = !out_valid || out_ready. Single registered output stage.
- Handshakes:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - out_* must stay stable while out_valid && !out_ready.
- in_ready = (state == DATA) && out_free. It is combinational from out_ready; there is no combinational path from in_valid.
- State DATA, on an input transfer:
  - fb = in_data ^ r3.
  - r3 <= r2 ^ fb*0x0F; r2 <= r1 ^ fb*0x36; r1 <= r0 ^ fb*0x78; r0 <= fb*0x40. All products are GF(256) multiplies.
  - out_data <= in_data; out_valid <= 1; out_parity <= 0; out_last <= 0; count increments.
  - When the transfer is the K-th symbol: count <= 0; state <= PARITY.
- State DATA, out_ready without an input transfer: out_valid <= 0.
- State PARITY, each cycle with out_free:
  - out_data <= r3; shift r3 <= r2, r2 <= r1, r1 <= r0, r0 <= 0.
  - out_valid <= 1; out_parity <= 1; count increments.
  - On the 4th parity load: out_last <= 1; count <= 0; state <= DATA. The LFSR is all-zero by construction.
- Latency and throughput:
  - Input accept to out_valid: 1 cycle.
  - Sustained throughput with out_ready held high: one symbol per cycle, K+4 cycles per codeword. in_ready is low during the 4 parity cycles.
- Backpressure: while out_ready is low with out_valid high, nothing advances (LFSR, count, state all hold).
- Simultaneous events: an output transfer and a new load in the same cycle is a normal pipelined step.
- The multiplier is a constant-coefficient GF(256) multiply; fully combinational, no extra pipeline stage.
- Reset mid-frame: the partial codeword is discarded and the next accepted symbol starts a new frame.
- No frame-boundary input: framing is count-based only.

Optional Feature:
- Macro: RS_PARITY_INVERT_EN.
- Defined: every parity symbol is bitwise inverted on output (out_data <= ~r3), as the CD Q-parity convention requires. The LFSR itself is unaffected. Data symbols are not inverted.
- Undefined: parity is output true.

Test Plan:
- All-zero frame (K=24, 24 x 0x00), out_ready=1 -> 24 x 0x00 then parity 0x00,0x00,0x00,0x00; out_last only on symbol 28; one symbol per cycle. With RS_PARITY_INVERT_EN: parity 0xFF x4.
- K=24, 23 x 0x00 then 0x01 -> parity 0x0F,0x36,0x78,0x40. With the macro: 0xF0,0xC9,0x87,0xBF.
- Random 24-symbol frames (1000 frames) checked against a software RS(28,24) model. Each codeword must evaluate to zero at x = 1, a, a^2, a^3.
- Random out_ready and in_valid gaps -> identical codeword stream to the no-stall run; out_* stable during stalls; in_ready=0 during parity.
- Assert rst after 10 data symbols, release, then send the second test-plan frame -> output cleared immediately on reset; the next codeword is correct with no residue from the aborted frame.
- K=1 parameterisation, data 0x01 -> output 0x01,0x0F,0x36,0x78,0x40 with out_parity 0,1,1,1,1 and out_last on the final symbol.
